// File: rtl/mem_dump_controller.sv
// mem_dump_controller
// Walks the data memory after a pipeline halt and streams each word (or only
// the dirty words) to the debug unit over a valid/ready handshake.
//
// Ports:
//   i_clock, i_soft_reset     clock, synchronous active-high reset
//   i_start, i_halt_detected  dump request; accepted only in IDLE while halted
//   o_control_address_mem     1 = memory takes its address from o_address_debug_unit
//   o_address_debug_unit      byte address of the word being read (index << 2)
//   i_dato_mem, i_bit_sucio   read data and dirty bit, valid one cycle after the address
//   o_data, o_addr, o_valid   emitted word, its byte address, and valid
//   i_ready                   consumer accept
//   o_busy, o_done, o_count   status: dump running, completion pulse, words transferred
//   o_debug                   {captured dirty flag, fsm state} for observation
//
// Handshake: o_valid is a registered state decode and never depends on i_ready.
// A transfer happens on a rising edge where o_valid & i_ready; o_data/o_addr
// stay stable while o_valid is high and i_ready is low.
module mem_dump_controller #(
  parameter int CANT_BITS_ADDR      = 12,
  parameter int CANT_BITS_REGISTROS = 32,
  parameter int RAM_DEPTH           = 1024,
  parameter int SOLO_SUCIOS         = 0
) (
  input  logic                              i_clock,
  input  logic                              i_soft_reset,
  input  logic                              i_start,
  input  logic                              i_halt_detected,
  output logic                              o_control_address_mem,
  output logic [CANT_BITS_ADDR-1:0]         o_address_debug_unit,
  input  logic [CANT_BITS_REGISTROS-1:0]    i_dato_mem,
  input  logic                              i_bit_sucio,
  output logic [CANT_BITS_REGISTROS-1:0]    o_data,
  output logic [CANT_BITS_ADDR-1:0]         o_addr,
  output logic                              o_valid,
  input  logic                              i_ready,
  output logic                              o_busy,
  output logic                              o_done,
  output logic [$clog2(RAM_DEPTH+1)-1:0]    o_count,
  output logic [3:0]                        o_debug
);

  localparam int IDX_W = $clog2(RAM_DEPTH);
  localparam int CNT_W = $clog2(RAM_DEPTH + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RAM_DEPTH - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ADDR    = 3'd1,
    CAPTURE = 3'd2,
    SEND    = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t           state, state_n;
  logic [IDX_W-1:0] idx, idx_n;
  logic [CNT_W-1:0] count, count_n;
  logic             capture;
  logic             flag_sucio;

  function automatic logic [CANT_BITS_ADDR-1:0] addr_of(input logic [IDX_W-1:0] i);
    return CANT_BITS_ADDR'({i, 2'b00});
  endfunction

  // Next-state logic. The last-index test comes before the increment, so
  // the index never wraps.
  always_comb begin
    state_n = state;
    idx_n   = idx;
    count_n = count;
    capture = 1'b0;
    case (state)
      IDLE: begin
        if (i_start && i_halt_detected) begin
          idx_n   = '0;
          count_n = '0;
          state_n = ADDR;
        end
      end
      ADDR: state_n = CAPTURE;
      CAPTURE: begin
        capture = 1'b1;
        if ((SOLO_SUCIOS == 0) || i_bit_sucio) begin
          state_n = SEND;
        end else if (idx == LAST_IDX) begin
          state_n = DONE;
        end else begin
          idx_n   = idx + IDX_W'(1);
          state_n = ADDR;
        end
      end
      SEND: begin
        if (i_ready) begin
          count_n = count + CNT_W'(1);
          if (idx == LAST_IDX) begin
            state_n = DONE;
          end else begin
            idx_n   = idx + IDX_W'(1);
            state_n = ADDR;
          end
        end
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_soft_reset) begin
      state                 <= IDLE;
      idx                   <= '0;
      count                 <= '0;
      flag_sucio            <= 1'b0;
      o_control_address_mem <= 1'b0;
      o_address_debug_unit  <= '0;
      o_data                <= '0;
      o_addr                <= '0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      count <= count_n;
      // Address select is held through the whole read/send of a word and
      // released as the sequencer leaves for DONE.
      o_control_address_mem <= (state_n == ADDR) || (state_n == CAPTURE) || (state_n == SEND);
      if (state_n == ADDR) begin
        o_address_debug_unit <= addr_of(idx_n);
      end
      if (capture) begin
        o_data     <= i_dato_mem;
        flag_sucio <= i_bit_sucio;
        o_addr     <= addr_of(idx);
      end
    end
  end

  assign o_valid = (state == SEND);
  assign o_busy  = (state != IDLE);
  assign o_done  = (state == DONE);
  assign o_count = count;
  assign o_debug = {flag_sucio, state};

endmodule

// File: tb/tb_mem_dump_controller.sv
// tb_mem_dump_controller
// Two instances: u_all emits every word, u_dirty emits only dirty words.
// Memory model: word i = 32'hA5000000 + i, dirty only at words 2 and 1023,
// synchronous read (data one cycle after the address).
module tb_mem_dump_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start0 = 1'b0, start1 = 1'b0, halt = 1'b0, ready = 1'b0;

  logic        ctrl0, valid0, busy0, done0;
  logic [11:0] adbg0, addr0;
  logic [31:0] data0, mem0;
  logic        sucio0;
  logic [10:0] count0;
  logic [3:0]  dbg0;

  logic        ctrl1, valid1, busy1, done1;
  logic [11:0] adbg1, addr1;
  logic [31:0] data1, mem1;
  logic        sucio1;
  logic [10:0] count1;
  logic [3:0]  dbg1;

  int checks = 0;
  int failures = 0;
  int xfer0 = 0, xfer1 = 0, done_cnt0 = 0, done_cnt1 = 0;
  logic [43:0] exp_q0[$];
  logic [43:0] exp_q1[$];

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  mem_dump_controller #(.CANT_BITS_ADDR(12), .CANT_BITS_REGISTROS(32),
                        .RAM_DEPTH(1024), .SOLO_SUCIOS(0)) u_all (
    .i_clock(clk), .i_soft_reset(rst), .i_start(start0), .i_halt_detected(halt),
    .o_control_address_mem(ctrl0), .o_address_debug_unit(adbg0),
    .i_dato_mem(mem0), .i_bit_sucio(sucio0), .o_data(data0), .o_addr(addr0),
    .o_valid(valid0), .i_ready(ready), .o_busy(busy0), .o_done(done0),
    .o_count(count0), .o_debug(dbg0));

  mem_dump_controller #(.CANT_BITS_ADDR(12), .CANT_BITS_REGISTROS(32),
                        .RAM_DEPTH(1024), .SOLO_SUCIOS(1)) u_dirty (
    .i_clock(clk), .i_soft_reset(rst), .i_start(start1), .i_halt_detected(halt),
    .o_control_address_mem(ctrl1), .o_address_debug_unit(adbg1),
    .i_dato_mem(mem1), .i_bit_sucio(sucio1), .o_data(data1), .o_addr(addr1),
    .o_valid(valid1), .i_ready(ready), .o_busy(busy1), .o_done(done1),
    .o_count(count1), .o_debug(dbg1));

  // ---------------- memory models ----------------
  always @(posedge clk) begin
    mem0   <= 32'hA5000000 + {22'd0, adbg0[11:2]};
    sucio0 <= (adbg0[11:2] == 10'd2) || (adbg0[11:2] == 10'd1023);
    mem1   <= 32'hA5000000 + {22'd0, adbg1[11:2]};
    sucio1 <= (adbg1[11:2] == 10'd2) || (adbg1[11:2] == 10'd1023);
  end

  // ---------------- checker / driver tasks ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- scoreboards ----------------
  always @(negedge clk) begin
    if (!rst && valid0 && ready) begin
      xfer0++;
      if (exp_q0.size() == 0) begin
        checks++; failures++;
        $display("FAIL xfer0_unexpected: got addr %0h data %0h expected none", addr0, data0);
      end else begin
        check("xfer0", {20'd0, addr0, data0}, {20'd0, exp_q0.pop_front()});
      end
    end
    if (!rst && valid1 && ready) begin
      xfer1++;
      if (exp_q1.size() == 0) begin
        checks++; failures++;
        $display("FAIL xfer1_unexpected: got addr %0h data %0h expected none", addr1, data1);
      end else begin
        check("xfer1", {20'd0, addr1, data1}, {20'd0, exp_q1.pop_front()});
      end
    end
    if (done0) done_cnt0++;
    if (done1) done_cnt1++;
  end

  typedef struct {
    logic        start, halt, ready;
    logic        chk_busy, busy, ctrl, valid, done;
    logic [11:0] adbg, addr;
    logic [31:0] data;
    logic [10:0] count;
  } vec_t;

  vec_t tbl[11];

  task automatic push_all0();
    for (int i = 0; i < 1024; i++) exp_q0.push_back({12'(i * 4), 32'hA5000000 + 32'(i)});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cyc;
    logic found;
    int done_snap;

    //            st    ht    rd    cb    busy  ctrl  vld   done  adbg    addr    data           count
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12'd0, 12'd0, 32'h0,        11'd0};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12'd0, 12'd0, 32'h0,        11'd0};
    tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 12'd0, 12'd0, 32'h0,        11'd0};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 12'd0, 12'd0, 32'h0,        11'd0};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 12'd0, 12'd0, 32'hA5000000, 11'd0};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 12'd0, 12'd0, 32'hA5000000, 11'd0};
    tbl[6]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 12'd0, 12'd0, 32'hA5000000, 11'd0};
    tbl[7]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 12'd4, 12'd0, 32'hA5000000, 11'd1};
    tbl[8]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 12'd4, 12'd0, 32'hA5000000, 11'd1};
    tbl[9]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 12'd4, 12'd4, 32'hA5000001, 11'd1};
    tbl[10] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 12'd8, 12'd4, 32'hA5000001, 11'd2};

    // ---- reset with random inputs ----
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      start0 = 1'($urandom_range(0, 1));
      start1 = 1'($urandom_range(0, 1));
      halt   = 1'($urandom_range(0, 1));
      ready  = 1'($urandom_range(0, 1));
      tick();
    end
    rst = 1'b0; start0 = 1'b0; start1 = 1'b0; halt = 1'b0; ready = 1'b0;
    check("rst_ctl0",   {ctrl0, valid0, busy0, done0}, 0);
    check("rst_addr0",  {adbg0, addr0}, 0);
    check("rst_data0",  data0, 0);
    check("rst_count0", count0, 0);
    check("rst_state0", dbg0, 0);
    check("rst_ctl1",   {ctrl1, valid1, busy1, done1}, 0);
    check("rst_addr1",  {adbg1, addr1}, 0);
    check("rst_data1",  data1, 0);
    check("rst_count1", count1, 0);
    tick();
    check("rst_idle0", {busy0, ctrl0}, 0);

    // ---- table: start filtering, first words, backpressure, start mid-dump ----
    push_all0();
    for (int i = 0; i < 11; i++) begin
      start0 = tbl[i].start; halt = tbl[i].halt; ready = tbl[i].ready;
      tick();
      if (tbl[i].chk_busy) begin
        check($sformatf("t%0d_busy", i), busy0, tbl[i].busy);
        check($sformatf("t%0d_ctrl", i), ctrl0, tbl[i].ctrl);
      end
      check($sformatf("t%0d_valid", i), valid0, tbl[i].valid);
      check($sformatf("t%0d_done", i),  done0,  tbl[i].done);
      check($sformatf("t%0d_adbg", i),  adbg0,  tbl[i].adbg);
      check($sformatf("t%0d_addr", i),  addr0,  tbl[i].addr);
      check($sformatf("t%0d_data", i),  data0,  tbl[i].data);
      check($sformatf("t%0d_count", i), count0, tbl[i].count);
    end
    start0 = 1'b0;

    // ---- reset during SEND of word 10 ----
    found = 1'b0;
    for (int n = 0; n < 100; n++) begin
      if (valid0 && addr0 == 12'd40) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    check("find_word10", found, 1);
    rst = 1'b1; ready = 1'b0;
    done_snap = done_cnt0;
    tick();
    check("mid_rst_ctl",   {ctrl0, valid0, busy0, done0}, 0);
    check("mid_rst_addr",  {adbg0, addr0}, 0);
    check("mid_rst_data",  data0, 0);
    check("mid_rst_count", count0, 0);
    rst = 1'b0;
    tick();
    check("mid_rst_nodone", done_cnt0 - done_snap, 0);
    check("mid_rst_idle", busy0, 0);
    exp_q0.delete();

    // ---- full dump, every word, ready held high ----
    push_all0();
    xfer0 = 0; done_cnt0 = 0;
    halt = 1'b1; ready = 1'b1; start0 = 1'b1;
    tick();                       // edge k
    start0 = 1'b0;
    cyc = 0;
    tick(); cyc++;                // after k+1
    check("full_busy", busy0, 1);
    check("full_ctrl", ctrl0, 1);
    check("full_adbg", adbg0, 0);
    tick(); cyc++;                // after k+2
    check("full_first_valid", valid0, 1);
    check("full_first_addr",  addr0, 0);
    check("full_first_data",  data0, 32'hA5000000);
    while (!done0 && cyc < 4000) begin
      tick(); cyc++;
    end
    check("full_done_seen", done0, 1);
    check("full_cycles", cyc, 3072);
    start0 = 1'b1;                // start in the DONE cycle is ignored
    tick();
    start0 = 1'b0;
    check("full_after_done", {busy0, ctrl0, done0}, 0);
    tick();
    check("full_no_restart", busy0, 0);
    check("full_count", count0, 1024);
    check("full_done_once", done_cnt0, 1);
    check("full_xfers", xfer0, 1024);
    check("full_queue_empty", exp_q0.size(), 0);

    // ---- dirty filter with backpressure on the first dirty word ----
    exp_q1.push_back({12'd8, 32'hA5000002});
    exp_q1.push_back({12'd4092, 32'hA50003FF});
    xfer1 = 0; done_cnt1 = 0;
    ready = 1'b0; halt = 1'b1; start1 = 1'b1;
    tick();
    start1 = 1'b0;
    halt = 1'b0;                  // dropping halt mid-dump must not abort
    found = 1'b0;
    for (int n = 0; n < 100; n++) begin
      if (valid1) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    check("dirty_valid_seen", found, 1);
    for (int n = 0; n < 5; n++) begin
      check("bp_valid", valid1, 1);
      check("bp_addr",  {adbg1, addr1}, {12'd8, 12'd8});
      check("bp_data",  data1, 32'hA5000002);
      check("bp_count", count1, 0);
      tick();
    end
    ready = 1'b1;
    tick();
    check("bp_one_xfer", {valid1, count1}, {1'b0, 11'd1});
    cyc = 0;
    while (!done1 && cyc < 3000) begin
      tick(); cyc++;
    end
    check("dirty_done_seen", done1, 1);
    tick();
    check("dirty_count", count1, 2);
    check("dirty_done_once", done_cnt1, 1);
    check("dirty_xfers", xfer1, 2);
    check("dirty_queue_empty", exp_q1.size(), 0);
    check("dirty_idle", busy1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
